// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the LEGv8 pipeline sequencing/hazard control.
//   state_t       : controller state encoding (S_INIT..S_HALT, 3-bit)
//   XZR_REG       : register index that never creates a data hazard
//   hazard_ctl_t  : the seven per-pipeline-register stall/flush bits
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_HALT  = 3'd3
    } state_t;

    localparam logic [4:0] XZR_REG = 5'd31;

    typedef struct packed {
        logic ifid_stall;
        logic idex_stall;
        logic exmem_stall;
        logic memwb_stall;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } hazard_ctl_t;

    localparam hazard_ctl_t CTL_NONE = '0;

endpackage

// File: rtl/load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. Flags the case where the
// instruction in EX is a load whose destination is read by the instruction
// in ID. The zero register never counts as a hazard source.
// Ports:
//   mem_read   in  1  instruction in EX is a load
//   ex_rd      in  5  destination register of the instruction in EX
//   id_rn      in  5  first source register of the instruction in ID
//   id_rm      in  5  second source register (after Reg2Loc mux)
//   id_uses_rm in  1  instruction in ID actually reads id_rm
//   lu         out 1  load-use hazard present
// ----------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter logic [4:0] XZR = XZR_REG
) (
    input  logic       mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rn,
    input  logic [4:0] id_rm,
    input  logic       id_uses_rm,
    output logic       lu
);

    logic rn_match;
    logic rm_match;

    assign rn_match = (ex_rd == id_rn);
    assign rm_match = id_uses_rm && (ex_rd == id_rm);
    assign lu       = mem_read && (ex_rd != XZR) && (rn_match || rm_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencing and hazard controller for the 5-stage LEGv8 pipeline.
// Drives PC write/reset and the stall/flush controls of the IFID, IDEX,
// EXMEM and MEMWB pipeline registers: startup fill, load-use stalls,
// taken-branch flushes and a halt -> drain -> resume sequence.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt
// performance counters (wrap modulo 2^CNT_W, cleared by reset_n).
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   IFID_rn, IFID_rm         source registers of the instruction in ID
//   IFID_uses_rm             instruction in ID reads IFID_rm
//   IDEX_C_MemRead, IDEX_rd  instruction in EX is a load / its destination
//   EXMEM_take_branch        branch resolved taken in MEM
//   halt_req                 level request to stop fetch and drain
//   pcWrite, pcReset         PC enable, PC synchronous clear
//   *_stall, *_flush         per-pipeline-register hold / bubble insert
//   halted                   controller sits in S_HALT
//   stall_cnt, flush_cnt     perf counters (HAZARD_PERF_CNT_EN only)
//   state                    current state encoding (debug visibility)
//
// In S_RUN and S_DRAIN the outputs are Mealy: they react in the same cycle
// to the hazard inputs so a stall/flush lands on the very next edge.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int         RESET_HOLD_CYCLES = 2,
    parameter int         DRAIN_CYCLES      = 4,
    parameter int         CNT_W             = 32,
    parameter logic [4:0] XZR               = XZR_REG
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       IFID_rn,
    input  logic [4:0]       IFID_rm,
    input  logic             IFID_uses_rm,
    input  logic             IDEX_C_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic             EXMEM_take_branch,
    input  logic             halt_req,
    output logic             pcWrite,
    output logic             pcReset,
    output logic             IFID_stall,
    output logic             IDEX_stall,
    output logic             EXMEM_stall,
    output logic             MEMWB_stall,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic             halted,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [2:0]       state
);

    // One counter serves both the reset-hold and the drain phases; it is
    // cleared on every phase entry, so 16 bits covers any sane setting.
    localparam int              HOLD_W     = 16;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DRAIN_LAST = HOLD_W'(DRAIN_CYCLES - 1);

    // Elaboration-time parameter sanity.
    if (RESET_HOLD_CYCLES < 1 || RESET_HOLD_CYCLES > 15) begin : g_bad_hold
        $error("RESET_HOLD_CYCLES must be in 1..15");
    end
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
        $error("DRAIN_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be >= 1");
    end

    state_t            state_q;
    logic [HOLD_W-1:0] cnt_q;
    logic              lu;
    logic              branch_flush;
    hazard_ctl_t       ctl;
    logic              pc_write_c;
    logic              pc_reset_c;
    logic              halted_c;

    load_use_detect #(
        .XZR (XZR)
    ) u_lu (
        .mem_read   (IDEX_C_MemRead),
        .ex_rd      (IDEX_rd),
        .id_rn      (IFID_rn),
        .id_rm      (IFID_rm),
        .id_uses_rm (IFID_uses_rm),
        .lu         (lu)
    );

    // A taken branch flushes the front of the pipe whenever instructions
    // are flowing (run or drain).
    assign branch_flush = EXMEM_take_branch &&
                          ((state_q == S_RUN) || (state_q == S_DRAIN));

    // ------------------------------------------------------------------
    // State register and phase counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= '0;
                    end
                end
                S_DRAIN: begin
                    // A late drop of halt_req does not abort the drain.
                    if (cnt_q == DRAIN_LAST) begin
                        state_q <= S_HALT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + HOLD_W'(1);
                    end
                end
                S_HALT: begin
                    if (!halt_req) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mux
    // ------------------------------------------------------------------
    always_comb begin
        ctl        = CTL_NONE;
        pc_write_c = 1'b0;
        pc_reset_c = 1'b0;
        halted_c   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (EXMEM_take_branch) begin
                    // Branch wins over load-use: the stalled instruction
                    // is on the wrong path anyway.
                    pc_write_c      = 1'b1;
                    ctl.ifid_flush  = 1'b1;
                    ctl.idex_flush  = 1'b1;
                    ctl.exmem_flush = 1'b1;
                end else if (lu) begin
                    ctl.ifid_stall = 1'b1;
                    ctl.idex_flush = 1'b1;
                end else begin
                    pc_write_c = 1'b1;
                end
            end
            S_DRAIN: begin
                if (EXMEM_take_branch) begin
                    // Let the PC capture the target so resume starts there.
                    pc_write_c      = 1'b1;
                    ctl.ifid_flush  = 1'b1;
                    ctl.idex_flush  = 1'b1;
                    ctl.exmem_flush = 1'b1;
                end else begin
                    // Fetch frozen; bubbles push the rest of the pipe out.
                    ctl.ifid_flush = 1'b1;
                end
            end
            S_HALT: begin
                ctl.ifid_stall  = 1'b1;
                ctl.idex_stall  = 1'b1;
                ctl.exmem_stall = 1'b1;
                ctl.memwb_stall = 1'b1;
                halted_c        = 1'b1;
            end
            default: begin
                // S_INIT and any illegal encoding look like reset.
                pc_reset_c      = 1'b1;
                ctl.ifid_flush  = 1'b1;
                ctl.idex_flush  = 1'b1;
                ctl.exmem_flush = 1'b1;
            end
        endcase
    end

    assign pcWrite     = pc_write_c;
    assign pcReset     = pc_reset_c;
    assign IFID_stall  = ctl.ifid_stall;
    assign IDEX_stall  = ctl.idex_stall;
    assign EXMEM_stall = ctl.exmem_stall;
    assign MEMWB_stall = ctl.memwb_stall;
    assign IFID_flush  = ctl.ifid_flush;
    assign IDEX_flush  = ctl.idex_flush;
    assign EXMEM_flush = ctl.exmem_flush;
    assign halted      = halted_c;
    assign state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic lu_stall;
    assign lu_stall = (state_q == S_RUN) && lu && !EXMEM_take_branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_branch_flush;
    assign unused_branch_flush = branch_flush;
`endif

endmodule
